adder_pool_scheduler: RTL and testbench

- Sequences a shared pool of fixed-latency two-operand adders (the team's two-cycle adder) to reduce a vector of up to N_OPS unsigned operands to one sum.
- Holds a work queue of partial sums and issues as many pairs per cycle as the pool allows.
- Tracks in-flight additions with an internal latency shift register and re-queues returning results.
- Sits between the operand register bank and the adder pool. Replaces hand-written per-cycle adder muxing.

---
 rtl/adder_pool_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_adder_pool_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pool_scheduler.sv
// adder_pool_scheduler: reduces up to N_OPS unsigned operands to one sum by
// feeding pairs of queued partial sums into a shared pool of fixed-latency
// adders and re-queueing each result as it comes back.
module adder_pool_scheduler #(
  parameter int N_OPS  = 30,
  parameter int DATA_W = 8,
  parameter int N_ADD  = 6,
  parameter int LAT    = 2
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [$clog2(N_OPS+1)-1:0]                     op_count,
  input  logic [N_OPS*DATA_W-1:0]                        operands,
  output logic                                           busy,
  output logic                                           done,
  output logic [DATA_W+$clog2(N_OPS)-1:0]                sum,
  output logic [N_ADD*(DATA_W+$clog2(N_OPS))-1:0]        add_a,
  output logic [N_ADD*(DATA_W+$clog2(N_OPS))-1:0]        add_b,
  output logic [N_ADD-1:0]                               add_vld,
  input  logic [N_ADD*(DATA_W+$clog2(N_OPS))-1:0]        add_res
);

  localparam int SUM_W = DATA_W + $clog2(N_OPS);
  localparam int CNT_W = $clog2(N_OPS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_next_state;

  // Work queue of partial sums; entries at and above r_count are don't-care.
  logic [N_OPS-1:0][SUM_W-1:0]     r_queue;
  logic [N_OPS-1:0][SUM_W-1:0]     w_shift_q;
  logic [N_OPS-1:0][SUM_W-1:0]     w_next_q;
  logic [CNT_W-1:0]                r_count;
  logic [CNT_W-1:0]                w_next_count;

  // Issue masks of the last LAT cycles; entry LAT-1 is the one returning now.
  logic [LAT-1:0][N_ADD-1:0]       r_infl;
  logic [N_ADD-1:0]                w_issue;
  logic [N_ADD-1:0]                w_exit;
  logic                            w_infl_any;

  logic [CNT_W-1:0]                w_opc;
  logic [CNT_W-1:0]                w_half;
  logic [CNT_W-1:0]                w_p;
  logic [CNT_W-1:0]                w_surv;
  logic [CNT_W-1:0]                w_idx;
  logic [SUM_W-1:0]                w_sum_load;

  logic                            r_busy;
  logic                            r_done;
  logic [SUM_W-1:0]                r_sum;

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;

  assign w_exit     = r_infl[LAT-1];
  assign w_infl_any = |r_infl;

  // Clamp the requested operand count to the queue depth.
  always_comb begin
    if (op_count > CNT_W'(N_OPS)) begin
      w_opc = CNT_W'(N_OPS);
    end else begin
      w_opc = op_count;
    end
  end

  // Pairs issued this cycle: min(N_ADD, count/2), only while running.
  always_comb begin
    w_half = {1'b0, r_count[CNT_W-1:1]};
    if (r_state != S_RUN) begin
      w_p = {CNT_W{1'b0}};
    end else if (int'(w_half) >= N_ADD) begin
      w_p = CNT_W'(N_ADD);
    end else begin
      w_p = w_half;
    end
    for (int k = 0; k < N_ADD; k++) begin
      w_issue[k] = (CNT_W'(k) < w_p);
    end
    w_surv    = r_count - {w_p[CNT_W-2:0], 1'b0};
    w_shift_q = r_queue >> (32'(w_p) * 32'(2 * SUM_W));
  end

  // Queue update: survivors move to the head, returning results append in adder order.
  always_comb begin
    w_next_q = w_shift_q;
    w_idx    = w_surv;
    for (int k = 0; k < N_ADD; k++) begin
      if (w_exit[k]) begin
        for (int j = 0; j < N_OPS; j++) begin
          if (w_idx == CNT_W'(j)) begin
            w_next_q[j] = add_res[k*SUM_W +: SUM_W];
          end else begin
            w_next_q[j] = w_next_q[j];
          end
        end
        w_idx = w_idx + CNT_W'(1);
      end else begin
        w_idx = w_idx;
      end
    end
    w_next_count = w_idx;
  end

  // Value captured into sum on entry to FIN (degenerate counts bypass the queue).
  always_comb begin
    if (r_state == S_IDLE) begin
      if (w_opc == {CNT_W{1'b0}}) begin
        w_sum_load = {SUM_W{1'b0}};
      end else begin
        w_sum_load = {{(SUM_W-DATA_W){1'b0}}, operands[DATA_W-1:0]};
      end
    end else begin
      w_sum_load = r_queue[0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; termination looks only at registered count and in-flight masks.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_opc < CNT_W'(2)) begin
            w_next_state = S_FIN;
          end else begin
            w_next_state = S_RUN;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if ((r_count <= CNT_W'(1)) && !w_infl_any) begin
          w_next_state = S_FIN;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_FIN: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // FSM outputs toward the pool: operand pairs from the queue head, idle adders zeroed.
  always_comb begin
    add_vld = w_issue;
    add_a   = {(N_ADD*SUM_W){1'b0}};
    add_b   = {(N_ADD*SUM_W){1'b0}};
    for (int k = 0; k < N_ADD; k++) begin
      if (w_issue[k]) begin
        add_a[k*SUM_W +: SUM_W] = r_queue[2*k];
        add_b[k*SUM_W +: SUM_W] = r_queue[2*k+1];
      end else begin
        add_a[k*SUM_W +: SUM_W] = {SUM_W{1'b0}};
        add_b[k*SUM_W +: SUM_W] = {SUM_W{1'b0}};
      end
    end
  end

  // Datapath registers: queue, in-flight tracking and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_queue <= {(N_OPS*SUM_W){1'b0}};
      r_count <= {CNT_W{1'b0}};
      r_infl  <= {(LAT*N_ADD){1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= {SUM_W{1'b0}};
    end else begin
      r_infl[0] <= w_issue;
      for (int i = 1; i < LAT; i++) begin
        r_infl[i] <= r_infl[i-1];
      end
      r_busy <= (w_next_state != S_IDLE);
      r_done <= (w_next_state == S_FIN);
      if (w_next_state == S_FIN) begin
        r_sum <= w_sum_load;
      end else begin
        r_sum <= r_sum;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < N_OPS; i++) begin
              if (CNT_W'(i) < w_opc) begin
                r_queue[i] <= {{(SUM_W-DATA_W){1'b0}}, operands[i*DATA_W +: DATA_W]};
              end else begin
                r_queue[i] <= {SUM_W{1'b0}};
              end
            end
            r_count <= w_opc;
          end else begin
            r_count <= r_count;
          end
        end
        S_RUN: begin
          r_queue <= w_next_q;
          r_count <= w_next_count;
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_pool_scheduler.sv
// Directed bench for adder_pool_scheduler with a LAT-cycle adder pool model.
module tb_adder_pool_scheduler;

  localparam int N_OPS  = 30;
  localparam int DATA_W = 8;
  localparam int N_ADD  = 6;
  localparam int LAT    = 2;
  localparam int SUM_W  = DATA_W + $clog2(N_OPS);
  localparam int CNT_W  = $clog2(N_OPS + 1);

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic [CNT_W-1:0]           op_count;
  logic [N_OPS*DATA_W-1:0]    operands;
  logic                       busy;
  logic                       done;
  logic [SUM_W-1:0]           sum;
  logic [N_ADD*SUM_W-1:0]     add_a;
  logic [N_ADD*SUM_W-1:0]     add_b;
  logic [N_ADD-1:0]           add_vld;
  logic [N_ADD*SUM_W-1:0]     add_res;

  int n_checks = 0;
  int n_fail   = 0;

  int               obs_done_n;
  int               obs_done_cyc;
  int               obs_busy_err;
  int               obs_vld_cycles;
  logic [SUM_W-1:0] obs_sum;
  logic [N_ADD-1:0] obs_vld_c1;

  logic [N_OPS*DATA_W-1:0] ops;

  always #5 clk = ~clk;

  adder_pool_scheduler #(
    .N_OPS (N_OPS),
    .DATA_W(DATA_W),
    .N_ADD (N_ADD),
    .LAT   (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_count(op_count),
    .operands(operands),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_vld (add_vld),
    .add_res (add_res)
  );

  // Pool model: N_ADD adders, each LAT cycles from operands to result, never reset.
  logic [N_ADD*SUM_W-1:0] pool_pipe [LAT];
  always @(posedge clk) begin
    for (int k = 0; k < N_ADD; k++) begin
      pool_pipe[0][k*SUM_W +: SUM_W] <= add_a[k*SUM_W +: SUM_W] + add_b[k*SUM_W +: SUM_W];
    end
    for (int i = 1; i < LAT; i++) begin
      pool_pipe[i] <= pool_pipe[i-1];
    end
  end
  assign add_res = pool_pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start in the current cycle; returns in cycle 1 of the run.
  task automatic launch(input int cnt, input logic [N_OPS*DATA_W-1:0] vec);
    op_count = CNT_W'(cnt);
    operands = vec;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Watch ncyc cycles from cycle 1; optionally pulse start in cycle pulse_cyc.
  task automatic observe(input int ncyc, input int pulse_cyc, input int pulse_cnt);
    obs_done_n     = 0;
    obs_done_cyc   = 0;
    obs_busy_err   = 0;
    obs_vld_cycles = 0;
    obs_sum        = '0;
    obs_vld_c1     = add_vld;
    for (int c = 1; c <= ncyc; c++) begin
      if (add_vld != '0) obs_vld_cycles++;
      if (done) begin
        obs_done_n++;
        if (obs_done_n == 1) begin
          obs_done_cyc = c;
          obs_sum      = sum;
        end
      end
      if (obs_done_n == 0 && busy !== 1'b1) obs_busy_err++;
      if (c == pulse_cyc) begin
        start    = 1'b1;
        op_count = CNT_W'(pulse_cnt);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    op_count = '0;
    operands = '0;
    tick();
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_vld", 32'(add_vld), 32'd0);
    check("reset_add_a_zero", 32'(add_a == '0), 32'd1);
    check("reset_add_b_zero", 32'(add_b == '0), 32'd1);
    rst = 1'b0;
    tick();

    // 30 operands 1..30 -> 465
    for (int i = 0; i < N_OPS; i++) ops[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
    launch(30, ops);
    observe(24, 0, 0);
    check("seq30_vld_first", 32'(obs_vld_c1), 32'h3F);
    check("seq30_done_once", 32'(obs_done_n), 32'd1);
    check("seq30_sum", 32'(obs_sum), 32'd465);
    check("seq30_latency_le20", 32'(obs_done_cyc >= 1 && obs_done_cyc <= 20), 32'd1);
    check("seq30_busy_held", 32'(obs_busy_err), 32'd0);
    check("seq30_busy_after", 32'(busy), 32'd0);
    check("seq30_sum_holds", 32'(sum), 32'd465);

    // 30 operands of 0xFF -> 7650
    for (int i = 0; i < N_OPS; i++) ops[i*DATA_W +: DATA_W] = 8'hFF;
    launch(30, ops);
    observe(24, 0, 0);
    check("ff30_done_once", 32'(obs_done_n), 32'd1);
    check("ff30_sum", 32'(obs_sum), 32'd7650);

    // Two operands: single issue in cycle 1, done in cycle 5
    ops = '1;
    ops[7:0]  = 8'd200;
    ops[15:8] = 8'd100;
    launch(2, ops);
    observe(10, 0, 0);
    check("two_vld_c1", 32'(obs_vld_c1), 32'h01);
    check("two_vld_cycles", 32'(obs_vld_cycles), 32'd1);
    check("two_done_cyc", 32'(obs_done_cyc), 32'd5);
    check("two_sum", 32'(obs_sum), 32'd300);

    // Zero operands -> immediate done with sum 0
    ops = '1;
    launch(0, ops);
    observe(6, 0, 0);
    check("zero_done_once", 32'(obs_done_n), 32'd1);
    check("zero_done_early", 32'(obs_done_cyc >= 1 && obs_done_cyc <= 2), 32'd1);
    check("zero_sum", 32'(obs_sum), 32'd0);
    check("zero_no_vld", 32'(obs_vld_cycles), 32'd0);

    // One operand -> sum is operand 0, pool never used
    ops = '1;
    ops[7:0] = 8'h5A;
    launch(1, ops);
    observe(6, 0, 0);
    check("one_done_once", 32'(obs_done_n), 32'd1);
    check("one_done_early", 32'(obs_done_cyc >= 1 && obs_done_cyc <= 2), 32'd1);
    check("one_sum", 32'(obs_sum), 32'd90);
    check("one_no_vld", 32'(obs_vld_cycles), 32'd0);

    // Seven operands 1..7 with leftover waits; stray start in cycle 2 ignored
    ops = '1;
    for (int i = 0; i < 7; i++) ops[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
    launch(7, ops);
    observe(20, 2, 30);
    check("odd7_done_once", 32'(obs_done_n), 32'd1);
    check("odd7_sum", 32'(obs_sum), 32'd28);
    check("odd7_done_cyc", 32'(obs_done_cyc), 32'd11);
    check("odd7_busy_held", 32'(obs_busy_err), 32'd0);

    // Count above N_OPS clamps to N_OPS: 31 requested, 30 ones summed
    for (int i = 0; i < N_OPS; i++) ops[i*DATA_W +: DATA_W] = 8'd1;
    launch(31, ops);
    observe(24, 0, 0);
    check("clamp_done_once", 32'(obs_done_n), 32'd1);
    check("clamp_sum", 32'(obs_sum), 32'd30);

    // start together with rst is ignored
    rst      = 1'b1;
    start    = 1'b1;
    op_count = CNT_W'(2);
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy0", 32'(busy), 32'd0);
    tick();
    check("rst_start_busy1", 32'(busy), 32'd0);
    check("rst_start_vld", 32'(add_vld), 32'd0);

    // Reset in the middle of a 30-operand run
    for (int i = 0; i < N_OPS; i++) ops[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
    launch(30, ops);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_vld", 32'(add_vld), 32'd0);
    observe(8, 0, 0);
    check("midrst_no_done", 32'(obs_done_n), 32'd0);
    check("midrst_no_vld", 32'(obs_vld_cycles), 32'd0);

    for (int i = 0; i < N_OPS; i++) ops[i*DATA_W +: DATA_W] = 8'd1;
    launch(30, ops);
    observe(24, 0, 0);
    check("after_rst_done_once", 32'(obs_done_n), 32'd1);
    check("after_rst_sum", 32'(obs_sum), 32'd30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
